// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller: FSM states, next-PC selects, queue entry.
package fetch_redirect_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRY_W = 2 * XLEN;

    typedef enum logic [1:0] {
        RC_BOOT    = 2'd0,
        RC_RUN     = 2'd1,
        RC_RECOVER = 2'd2
    } rc_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_HOLD   = 2'd1,
        NPC_DEC    = 2'd2,
        NPC_ACTUAL = 2'd3
    } npc_sel_e;

    // One in-flight prediction: where fetch went, and where it would fall through.
    typedef struct packed {
        logic [XLEN-1:0] pred_next;
        logic [XLEN-1:0] fallthru;
    } pred_entry_t;

endpackage

// File: rtl/fetch_redirect_ctrl_pred_queue.sv
// In-order prediction FIFO; clear wins over push, push into a full queue needs a same-cycle pop.
module fetch_redirect_ctrl_pred_queue
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t push_data,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]        wr_ptr_q;
    logic [PW:0]        rd_ptr_q;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~clear & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: records decode predictions, checks them at execute, redirects and squashes.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        dec_valid,
    input  logic        dec_is_ctrl,
    input  logic [31:0] dec_pc,
    input  logic [31:0] dec_target,
    input  logic        dec_taken,
    input  logic        ex_valid,
    input  logic        ex_is_ctrl,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [31:0] fetch_pc,
    output logic        kill_fetch,
    output logic        kill_dec,
    output logic        mispredict,
    output logic        dec_hold,
    output logic        proto_err,
    output logic [31:0] ctrl_cnt,
    output logic [31:0] mispred_cnt
);

    rc_state_e   state_q;
    rc_state_e   state_d;
    npc_sel_e    npc_sel;
    logic [31:0] fetch_pc_d;
    logic [31:0] actual;
    logic [31:0] fallthru;
    logic        q_full;
    logic        q_empty;
    logic        pop;
    logic        push;
    pred_entry_t head;
    pred_entry_t push_data;

    assign fallthru   = dec_pc + 32'd4;
    assign push_data  = '{pred_next: (dec_taken ? dec_target : fallthru), fallthru: fallthru};
    assign pop        = ex_valid & ex_is_ctrl & ~q_empty;
    assign actual     = ex_taken ? ex_target : head.fallthru;
    assign mispredict = pop & (actual != head.pred_next);
    assign dec_hold   = q_full & dec_valid & dec_is_ctrl & ~pop;
    assign push       = dec_valid & dec_is_ctrl & ~stall & ~dec_hold & ~mispredict
                      & (state_q == RC_RUN);

    fetch_redirect_ctrl_pred_queue #(
        .DEPTH (QDEPTH)
    ) u_pred_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (mispredict),
        .push_data (push_data),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RC_BOOT;
        else        state_q <= state_d;
    end

    // Next state, squash outputs and next-PC select.
    always_comb begin
        state_d    = state_q;
        kill_fetch = 1'b0;
        kill_dec   = 1'b0;
        npc_sel    = NPC_SEQ;
        case (state_q)
            RC_BOOT: begin
                kill_dec = 1'b1;
                state_d  = RC_RUN;
            end
            RC_RUN: begin
                if (mispredict) state_d = RC_RECOVER;
            end
            RC_RECOVER: begin
                kill_dec = 1'b1;
                state_d  = mispredict ? RC_RECOVER : RC_RUN;
            end
            default: begin
                kill_dec = 1'b1;
                state_d  = RC_BOOT;
            end
        endcase
        if (mispredict) begin
            npc_sel    = NPC_ACTUAL;
            kill_fetch = 1'b1;
            kill_dec   = 1'b1;
        end else if (push && dec_taken) begin
            npc_sel    = NPC_DEC;
            kill_fetch = 1'b1;
        end else if (stall) begin
            npc_sel    = NPC_HOLD;
        end
    end

    // Next fetch PC mux.
    always_comb begin
        fetch_pc_d = fetch_pc + 32'd4;
        case (npc_sel)
            NPC_ACTUAL: fetch_pc_d = actual;
            NPC_DEC:    fetch_pc_d = dec_target;
            NPC_HOLD:   fetch_pc_d = fetch_pc;
            default:    fetch_pc_d = fetch_pc + 32'd4;
        endcase
    end

    // Fetch PC, sticky protocol error and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            proto_err   <= 1'b0;
            ctrl_cnt    <= '0;
            mispred_cnt <= '0;
        end else begin
            fetch_pc <= fetch_pc_d;
            if (ex_valid && ex_is_ctrl && q_empty) proto_err <= 1'b1;
            if (pop)        ctrl_cnt    <= ctrl_cnt + 32'd1;
            if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule
